parking_occupancy_tracker: RTL and testbench

- Sequential producer of the 4-bit `parked` count consumed by the empty-space subtractor chain (empty = 8 - parked).
- Sits between the entry/exit gate sensors and the occupancy display path.
- Arbitrates one shared gate mechanism between entry and exit requests.
- Opens the gate with a timeout, then increments or decrements the count on a confirmed pass.

---
 rtl/parking_occupancy_tracker.sv | 104 ++++++++++
 tb/tb_parking_occupancy_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_tracker.sv
// Parking lot occupancy tracker: arbitrates one gate mechanism between entry and
// exit requests, times out unused openings and keeps the saturating car count.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no gate open; evaluate exit (priority) then entry requests
// ENTRY_OPEN | entry gate open, waiting for pass or timeout
// EXIT_OPEN  | exit gate open, waiting for pass or timeout
// COOLDOWN   | one closed cycle so a held request cannot retrigger at once
module parking_occupancy_tracker #(
    parameter int unsigned CAPACITY = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass,
    output logic [3:0] parked,
    output logic       full,
    output logic       entry_open,
    output logic       exit_open,
    output logic       deny
);

    localparam logic [3:0] CAP_W    = 4'(CAPACITY);
    localparam logic [7:0] TIMER_TC = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2,
        COOLDOWN   = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] timer_q;
    logic [3:0] parked_q;
    logic       entry_open_q;
    logic       exit_open_q;
    logic       deny_q;

    logic [3:0] parked_up_d;
    logic [3:0] parked_dn_d;

    // Saturation is defensive only: the IDLE guards already keep the count in range.
    always_comb begin
        parked_up_d = (parked_q >= CAP_W) ? parked_q : parked_q + 4'd1;
        parked_dn_d = (parked_q == 4'd0)  ? parked_q : parked_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            parked_q     <= 4'd0;
            entry_open_q <= 1'b0;
            exit_open_q  <= 1'b0;
            deny_q       <= 1'b0;
        end else begin
            deny_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exit_req && parked_q != 4'd0) begin
                        exit_open_q <= 1'b1;
                        timer_q     <= 8'd0;
                        state_q     <= EXIT_OPEN;
                    end else if (entry_req && parked_q < CAP_W) begin
                        entry_open_q <= 1'b1;
                        timer_q      <= 8'd0;
                        state_q      <= ENTRY_OPEN;
                    end else if (entry_req) begin
                        deny_q  <= 1'b1;
                        state_q <= COOLDOWN;
                    end
                end
                ENTRY_OPEN, EXIT_OPEN: begin
                    // pass is checked first so a pass on the timeout cycle still counts
                    if (pass) begin
                        parked_q     <= (state_q == ENTRY_OPEN) ? parked_up_d : parked_dn_d;
                        entry_open_q <= 1'b0;
                        exit_open_q  <= 1'b0;
                        state_q      <= COOLDOWN;
                    end else if (timer_q == TIMER_TC) begin
                        entry_open_q <= 1'b0;
                        exit_open_q  <= 1'b0;
                        state_q      <= COOLDOWN;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                COOLDOWN: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign parked     = parked_q;
    assign full       = (parked_q == CAP_W);
    assign entry_open = entry_open_q;
    assign exit_open  = exit_open_q;
    assign deny       = deny_q;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Scoreboard bench for parking_occupancy_tracker: a cycle model predicts outputs
// when inputs are driven; predictions are popped and compared after each edge.
module tb_parking_occupancy_tracker;

    localparam int CAPACITY = 8;
    localparam int TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       pass = 1'b0;
    logic [3:0] parked;
    logic       full;
    logic       entry_open;
    logic       exit_open;
    logic       deny;

    parking_occupancy_tracker #(.CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .pass       (pass),
        .parked     (parked),
        .full       (full),
        .entry_open (entry_open),
        .exit_open  (exit_open),
        .deny       (deny)
    );

    always #5 clk = ~clk;

    typedef struct {
        int parked;
        int full;
        int eo;
        int xo;
        int deny;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // model: which gate is open (0 none, 1 entry, 2 exit), cycles it has been open
    int m_parked = 0;
    int m_gate   = 0;
    int m_open   = 0;
    int m_cool   = 0;

    int cnt_eo;
    int cnt_xo;
    int cnt_deny;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step(input logic en, input logic ex, input logic ps, input logic r);
        exp_t e;
        int   m_deny;
        @(negedge clk);
        entry_req = en;
        exit_req  = ex;
        pass      = ps;
        rst       = r;
        m_deny    = 0;
        if (r) begin
            m_parked = 0; m_gate = 0; m_open = 0; m_cool = 0;
        end else if (m_gate != 0) begin
            m_open++;
            if (ps) begin
                m_parked = (m_gate == 1) ? m_parked + 1 : m_parked - 1;
                m_gate = 0; m_cool = 1;
            end else if (m_open == TIMEOUT) begin
                m_gate = 0; m_cool = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else if (ex && m_parked > 0) begin
            m_gate = 2; m_open = 0;
        end else if (en && m_parked < CAPACITY) begin
            m_gate = 1; m_open = 0;
        end else if (en) begin
            m_deny = 1; m_cool = 1;
        end
        e.parked = m_parked;
        e.full   = (m_parked == CAPACITY) ? 1 : 0;
        e.eo     = (m_gate == 1) ? 1 : 0;
        e.xo     = (m_gate == 2) ? 1 : 0;
        e.deny   = m_deny;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("parked",     int'(parked),     e.parked);
        chk("full",       int'(full),       e.full);
        chk("entry_open", int'(entry_open), e.eo);
        chk("exit_open",  int'(exit_open),  e.xo);
        chk("deny",       int'(deny),       e.deny);
        if (entry_open && exit_open) chk("mutex", 1, 0);
        cnt_eo   += int'(entry_open);
        cnt_xo   += int'(exit_open);
        cnt_deny += int'(deny);
    endtask

    task automatic clear_counts();
        cnt_eo = 0; cnt_xo = 0; cnt_deny = 0;
    endtask

    task automatic do_entry();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic do_exit();
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        clear_counts();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // basic entry: request held 2 cycles, pass on 4th open cycle
        clear_counts();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("basic_open_cycles", cnt_eo, 4);
        chk("basic_parked", int'(parked), 1);

        // fill to capacity then hold a refused entry
        for (int i = 0; i < CAPACITY - 1; i++) do_entry();
        chk("fill_parked", int'(parked), CAPACITY);
        chk("fill_full", int'(full), 1);
        clear_counts();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        chk("deny_pulses", cnt_deny, 3);
        chk("deny_no_open", cnt_eo, 0);
        step(0, 0, 0, 0);

        // down to 3, then simultaneous requests: exit wins
        for (int i = 0; i < 5; i++) do_exit();
        chk("sim_start", int'(parked), 3);
        step(1, 1, 0, 0);
        chk("sim_exit_wins", int'(exit_open), 1);
        step(1, 1, 1, 0);
        chk("sim_after_exit", int'(parked), 2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("sim_after_entry", int'(parked), 3);

        // timeout with no pass, then pass on the final open cycle
        clear_counts();
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        chk("timeout_open_cycles", cnt_eo, TIMEOUT);
        chk("timeout_parked", int'(parked), 3);
        step(1, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("timeout_edge_pass", int'(parked), 4);

        // empty lot: exit ignored, stray passes ignored
        for (int i = 0; i < 4; i++) do_exit();
        clear_counts();
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("empty_no_gate", cnt_eo + cnt_xo, 0);
        chk("empty_no_deny", cnt_deny, 0);
        chk("empty_parked", int'(parked), 0);

        // reset coincident with pass while exit gate open
        for (int i = 0; i < 5; i++) do_entry();
        step(0, 1, 0, 0);
        chk("rst_pre_open", int'(exit_open), 1);
        step(0, 0, 1, 1);
        chk("rst_parked", int'(parked), 0);
        step(0, 0, 0, 0);
        do_entry();
        chk("rst_recover", int'(parked), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
